multi_lock_manager: RTL and testbench

MULTI_LOCK_MANAGER -- requirements
Module: multi_lock_manager

---
 rtl/ompss_lock_pkg.sv | 16 +
 rtl/lock_owner_table.sv | 40 ++++
 rtl/multi_lock_manager.sv | 157 +++++++++++++++
 tb/tb_multi_lock_manager.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ompss_lock_pkg.sv
// Shared constants for the multi-accelerator lock manager:
// opcodes, acknowledge values and FSM state encoding.
package ompss_lock_pkg;

    localparam logic [7:0] OP_ACQUIRE = 8'h04;
    localparam logic [7:0] OP_RELEASE = 8'h06;

    localparam logic [63:0] RESP_ACK  = 64'h1;
    localparam logic [63:0] RESP_NACK = 64'h0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lock_state_e;

endpackage

// File: rtl/lock_owner_table.sv
// Per-lock held bit and owner id, one write port and one
// combinational read port; held bits are also exported.
module lock_owner_table #(
    parameter int NUM_LOCKS = 8,
    parameter int TW        = 4,
    parameter int IW        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic                 wr_held,
    input  logic [TW-1:0]        wr_owner,
    input  logic [IW-1:0]        rd_addr,
    output logic                 rd_held,
    output logic [TW-1:0]        rd_owner,
    output logic [NUM_LOCKS-1:0] held
);

    logic [NUM_LOCKS-1:0] held_q;
    logic [TW-1:0]        owner_q [NUM_LOCKS];

    // Storage update: cleared on reset, single entry written per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
            for (int i = 0; i < NUM_LOCKS; i++) begin
                owner_q[i] <= '0;
            end
        end else if (wr_en) begin
            held_q[wr_addr]  <= wr_held;
            owner_q[wr_addr] <= wr_owner;
        end
    end

    assign rd_held  = held_q[rd_addr];
    assign rd_owner = owner_q[rd_addr];
    assign held     = held_q;

endmodule

// File: rtl/multi_lock_manager.sv
// Lock arbiter for accelerators: ACQUIRE/RELEASE requests on an
// input stream, grants/NACKs returned on an acknowledge stream.
module multi_lock_manager
    import ompss_lock_pkg::*;
#(
    parameter int MAX_ACCS  = 16,
    parameter int NUM_LOCKS = 8
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic                        lock_in_tvalid,
    output logic                        lock_in_tready,
    input  logic [$clog2(MAX_ACCS)-1:0] lock_in_tid,
    input  logic [63:0]                 lock_in_tdata,
    output logic                        lock_out_tvalid,
    input  logic                        lock_out_tready,
    output logic [$clog2(MAX_ACCS)-1:0] lock_out_tdest,
    output logic [63:0]                 lock_out_tdata,
    output logic                        lock_out_tlast,
    output logic [NUM_LOCKS-1:0]        locks_held,
    output logic                        err
);

    localparam int TW = $clog2(MAX_ACCS);
    localparam int IW = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

    lock_state_e state_q, state_d;

    logic [7:0]    op;
    logic [7:0]    id;
    logic          id_ok;
    logic          is_acq;
    logic          is_rel;
    logic          own;
    logic          rd_held;
    logic [TW-1:0] rd_owner;

    logic          wr_en;
    logic          wr_held;
    logic          load;
    logic [63:0]   resp;
    logic          err_set;

    logic [63:0]   data_q;
    logic [TW-1:0] dest_q;
    logic          err_q;

    logic          unused_bits;

    assign op     = lock_in_tdata[7:0];
    assign id     = lock_in_tdata[15:8];
    assign id_ok  = {1'b0, id} < 9'(NUM_LOCKS);
    assign is_acq = (op == OP_ACQUIRE);
    assign is_rel = (op == OP_RELEASE);
    assign own    = rd_held && (rd_owner == lock_in_tid);

    assign unused_bits = ^lock_in_tdata[63:16];

    lock_owner_table #(
        .NUM_LOCKS (NUM_LOCKS),
        .TW        (TW),
        .IW        (IW)
    ) u_table (
        .clk      (aclk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (id[IW-1:0]),
        .wr_held  (wr_held),
        .wr_owner (lock_in_tid),
        .rd_addr  (id[IW-1:0]),
        .rd_held  (rd_held),
        .rd_owner (rd_owner),
        .held     (locks_held)
    );

    // Ready only in IDLE and never while reset is asserted
    assign lock_in_tready  = (state_q == ST_IDLE) && !rst;
    assign lock_out_tvalid = (state_q == ST_RESP) && !rst;
    assign lock_out_tlast  = lock_out_tvalid;
    assign lock_out_tdata  = data_q;
    assign lock_out_tdest  = dest_q;
    assign err             = err_q;

    // State register
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request decode, table writes and next state
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_held = 1'b0;
        load    = 1'b0;
        resp    = RESP_NACK;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lock_in_tvalid && lock_in_tready) begin
                    unique case (1'b1)
                        is_acq: begin
                            load    = 1'b1;
                            state_d = ST_RESP;
                            if (!id_ok) begin
                                err_set = 1'b1;
                            end else if (!rd_held) begin
                                wr_en   = 1'b1;
                                wr_held = 1'b1;
                                resp    = RESP_ACK;
                            end else if (own) begin
                                resp    = RESP_ACK;
                            end
                        end
                        is_rel: begin
                            if (id_ok && own) begin
                                wr_en = 1'b1;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        default: begin
                            err_set = 1'b1;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                if (lock_out_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response capture and sticky error flag
    always_ff @(posedge aclk) begin
        if (rst) begin
            data_q <= '0;
            dest_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q <= resp;
                dest_q <= lock_in_tid;
            end
            err_q <= err_q | err_set;
        end
    end

endmodule

// File: tb/tb_multi_lock_manager.sv
// Scoreboard bench for multi_lock_manager: expected acknowledges
// are queued at issue time and checked by an output monitor.
module tb_multi_lock_manager;
    import ompss_lock_pkg::*;

    localparam int TW = 4;

    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic          lock_in_tvalid = 1'b0;
    logic          lock_in_tready;
    logic [TW-1:0] lock_in_tid = '0;
    logic [63:0]   lock_in_tdata = '0;
    logic          lock_out_tvalid;
    logic          lock_out_tready = 1'b1;
    logic [TW-1:0] lock_out_tdest;
    logic [63:0]   lock_out_tdata;
    logic          lock_out_tlast;
    logic [7:0]    locks_held;
    logic          err;

    int errors = 0;
    int checks = 0;
    int w;

    logic [TW+63:0] exp_q [$];
    logic [TW+63:0] mon_e;

    multi_lock_manager #(
        .MAX_ACCS  (16),
        .NUM_LOCKS (8)
    ) dut (
        .aclk            (aclk),
        .rst             (rst),
        .lock_in_tvalid  (lock_in_tvalid),
        .lock_in_tready  (lock_in_tready),
        .lock_in_tid     (lock_in_tid),
        .lock_in_tdata   (lock_in_tdata),
        .lock_out_tvalid (lock_out_tvalid),
        .lock_out_tready (lock_out_tready),
        .lock_out_tdest  (lock_out_tdest),
        .lock_out_tdata  (lock_out_tdata),
        .lock_out_tlast  (lock_out_tlast),
        .locks_held      (locks_held),
        .err             (err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted acknowledge must match the queue head
    always @(negedge aclk) begin
        if (!rst && lock_out_tvalid && lock_out_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got dest=%0d data=%0h expected none",
                         lock_out_tdest, lock_out_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_dest", 64'(lock_out_tdest), 64'(mon_e[TW+63:64]));
                chk("resp_data", lock_out_tdata, mon_e[63:0]);
                chk("resp_tlast", 64'(lock_out_tlast), 64'h1);
            end
        end
    end

    task automatic send(input int tid, input logic [7:0] op,
                        input logic [7:0] id, input bit rsp,
                        input logic [63:0] ed, output int waits);
        waits = 0;
        @(negedge aclk);
        while (!lock_in_tready && waits < 50) begin
            @(negedge aclk);
            waits++;
        end
        if (waits >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
            return;
        end
        lock_in_tvalid = 1'b1;
        lock_in_tid    = TW'(tid);
        lock_in_tdata  = {48'hABCD_0123_4567, id, op};
        if (rsp) exp_q.push_back({TW'(tid), ed});
        @(posedge aclk);
        #1;
        lock_in_tvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge aclk);
        chk("rst_held", 64'(locks_held), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_valid", 64'(lock_out_tvalid), 64'h0);
        chk("rst_in_ready", 64'(lock_in_tready), 64'h0);
        rst = 1'b0;
        @(negedge aclk);
        chk("post_rst_in_ready", 64'(lock_in_tready), 64'h1);
        chk("post_rst_valid", 64'(lock_out_tvalid), 64'h0);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_in_ready", 64'(lock_in_tready), 64'h0);
        chk("reset_valid", 64'(lock_out_tvalid), 64'h0);
        chk("reset_held", 64'(locks_held), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        chk("reset_tdata", lock_out_tdata, 64'h0);
        chk("reset_tdest", 64'(lock_out_tdest), 64'h0);
        rst = 1'b0;

        send(3, OP_ACQUIRE, 8'd2, 1'b1, RESP_ACK, w);
        chk("acq_valid_lat1", 64'(lock_out_tvalid), 64'h1);
        chk("acq_held", 64'(locks_held), 64'h04);

        send(5, OP_ACQUIRE, 8'd2, 1'b1, RESP_NACK, w);
        chk("nack_held", 64'(locks_held), 64'h04);

        send(3, OP_RELEASE, 8'd2, 1'b0, RESP_NACK, w);
        chk("rel_held", 64'(locks_held), 64'h00);
        chk("rel_no_valid", 64'(lock_out_tvalid), 64'h0);
        chk("rel_err", 64'(err), 64'h0);

        send(5, OP_ACQUIRE, 8'd2, 1'b1, RESP_ACK, w);
        chk("retry_held", 64'(locks_held), 64'h04);
        send(5, OP_ACQUIRE, 8'd2, 1'b1, RESP_ACK, w);
        chk("reentrant_held", 64'(locks_held), 64'h04);

        send(1, OP_RELEASE, 8'd4, 1'b0, RESP_NACK, w);
        chk("free_rel_err", 64'(err), 64'h1);
        chk("free_rel_no_valid", 64'(lock_out_tvalid), 64'h0);

        send(5, OP_RELEASE, 8'd2, 1'b0, RESP_NACK, w);
        chk("own_rel_held", 64'(locks_held), 64'h00);
        chk("err_sticky", 64'(err), 64'h1);

        pulse_reset();

        send(2, OP_ACQUIRE, 8'd8, 1'b1, RESP_NACK, w);
        chk("bad_id_err", 64'(err), 64'h1);
        chk("bad_id_held", 64'(locks_held), 64'h00);

        pulse_reset();

        send(2, 8'h07, 8'd1, 1'b0, RESP_NACK, w);
        chk("bad_op_err", 64'(err), 64'h1);
        chk("bad_op_no_valid", 64'(lock_out_tvalid), 64'h0);

        lock_out_tready = 1'b0;
        send(6, OP_ACQUIRE, 8'd1, 1'b1, RESP_ACK, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("bp_valid", 64'(lock_out_tvalid), 64'h1);
            chk("bp_data", lock_out_tdata, 64'h1);
            chk("bp_dest", 64'(lock_out_tdest), 64'h6);
            chk("bp_in_ready", 64'(lock_in_tready), 64'h0);
        end
        @(posedge aclk);
        #1;
        lock_out_tready = 1'b1;
        send(7, OP_ACQUIRE, 8'd3, 1'b1, RESP_ACK, w);
        chk("bp_next_accept_waits", 64'(w), 64'h1);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        lock_out_tready = 1'b0;
        send(8, OP_ACQUIRE, 8'd5, 1'b1, RESP_ACK, w);
        chk("three_held", 64'(locks_held), 64'h2A);
        chk("resp_pending", 64'(lock_out_tvalid), 64'h1);

        pulse_reset();

        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
